irq_event_packer: RTL and testbench
===================================

IRQ_EVENT_PACKER -- requirements
Module: irq_event_packer

Interface
REQ-001 The block SHALL have parameter NIRQ, default 32, meaning IRQ vector width; legal values are multiples of 8 from 8 to 64.
REQ-002 The block SHALL have parameter HDR, default 8'hF1, meaning the packet header byte that marks an async IRQ event in the host stream.
REQ-003 The block SHALL have port CLK  input  1  system clock; the block uses one clock.
REQ-004 The block SHALL have port RESETn  input  1  reset; asynchronous and active-low.
REQ-005 The block SHALL have port ENABLE  input  1  event reporting enable (IRQ scan on).
REQ-006 The block SHALL have port IRQ_VALID  input  1  single-cycle strobe indicating that IRQ_VEC holds a new scan result.
REQ-007 The block SHALL have port IRQ_VEC  input  NIRQ  pending-IRQ snapshot, bit i = IRQ i pending.
REQ-008 The block SHALL have port WREN  output  1  byte write strobe toward the host TX arbiter (IRQ channel).
REQ-009 The block SHALL have port WRDATA  output  8  byte written when WREN=1.
REQ-010 The block SHALL have port WRFULL  input  1  downstream full; no write occurs while it is high.
REQ-011 The block SHALL have port BUSY  output  1  high while a packet is in flight or a vector is pending.
REQ-012 The block SHALL have port DROPPED  output  8  saturating count of unsent vectors that were superseded.

Function
REQ-013 Packet format SHALL be: HDR, then NIRQ/8 vector bytes, least-significant byte first; the total is 1+NIRQ/8 bytes.
REQ-014 The block SHALL hold the registers last_sent (NIRQ), pend_vec (NIRQ), pend flag, shadow (NIRQ), and byte counter (3 bits).
REQ-015 The reference vector SHALL be defined as shadow's incoming value in a cycle where IDLE loads shadow, and last_sent otherwise.
REQ-016 On IRQ_VALID with ENABLE=1, pend_vec SHALL load IRQ_VEC and pend SHALL be set if IRQ_VEC differs from the reference vector, else cleared.
REQ-017 If IRQ_VALID overwrites pend_vec while pend=1 and IRQ_VEC differs from pend_vec, DROPPED SHALL increment, saturating at 255.
REQ-018 The FSM SHALL have states IDLE, SEND_HDR, and SEND_DATA.
REQ-019 In IDLE with pend=1 and ENABLE=1, the FSM SHALL load shadow<=pend_vec and last_sent<=pend_vec, clear pend (unless set again per REQ-016 in the same cycle), and go to SEND_HDR.
REQ-020 WREN SHALL equal (state!=IDLE) AND !WRFULL, combinationally; WRDATA SHALL be HDR in SEND_HDR and shadow byte[counter] in SEND_DATA.
REQ-021 State and counter SHALL advance only on cycles with WREN=1; SEND_HDR goes to SEND_DATA with counter=0; SEND_DATA at counter=NIRQ/8-1 goes to IDLE.
REQ-022 While WRFULL=1, WRDATA SHALL remain stable and no byte SHALL be skipped or duplicated.
REQ-023 Latency SHALL be: IRQ_VALID sampled in cycle N with a changed vector in IDLE gives the HDR write (WRFULL=0) in cycle N+2, and data bytes SHALL follow in consecutive cycles.
REQ-024 Changes arriving during a packet SHALL coalesce: at most one follow-up packet is sent, carrying the latest pend_vec.
REQ-025 On ENABLE deassert mid-packet, the current packet SHALL complete untruncated; pend SHALL clear, IRQ_VALID SHALL be ignored, and last_sent SHALL be set to 0 when the FSM is in IDLE with ENABLE=0.
REQ-026 BUSY SHALL equal (state!=IDLE) OR pend.

Reset
REQ-027 On RESETn=0, the block SHALL immediately set state=IDLE, WREN=0, WRDATA=0, BUSY=0, DROPPED=0, pend=0, counter=0, and last_sent, pend_vec and shadow all to 0.
REQ-028 A reset mid-packet SHALL abandon the packet, with no resumption after release.

Structure
REQ-029 The state enum and the IRQ_HDR default constant SHALL live in shared package flexdbg_pkg; NIRQ-derived widths SHALL be localparams.
REQ-030 The block SHALL be a single module with no sub-module; the byte select SHALL be an indexed part-select of shadow.

Verification
REQ-031 NIRQ=32, WRFULL=0, IRQ_VALID with 32'h0000_0001 in cycle N -> WREN in cycles N+2..N+6 with bytes F1,01,00,00,00.
REQ-032 IRQ_VALID repeating 32'h0000_0001 after that packet -> no WREN and BUSY stays 0.
REQ-033 WRFULL high for 3 cycles while the byte index is 1 -> WREN low for those cycles, WRDATA held at 00, and the full 5-byte sequence is delivered exactly once.
REQ-034 During a packet, IRQ_VALID with 32'h10, then IRQ_VALID with 32'h20 -> exactly one follow-up packet F1,20,00,00,00, and DROPPED=1.
REQ-035 RESETn low during SEND_DATA -> WREN=0 in the same cycle; after release, IRQ_VALID with 0 -> no packet, and 32'h8000_0000 -> F1,00,00,00,80.
REQ-036 ENABLE dropped during SEND_HDR -> all 5 bytes are still sent, subsequent IRQ_VALID is ignored, and after re-enable a vector of 0 produces no packet.

Source files
------------

// File: rtl/flexdbg_pkg.sv
// Shared types and constants for the debug-host stream blocks.
// Holds the packer FSM encoding and the async IRQ packet header.
package flexdbg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HDR,
    SEND_DATA
  } state_t;

  localparam logic [7:0] IRQ_HDR = 8'hF1;

endpackage

// File: rtl/irq_event_packer.sv
// Packs changed IRQ pending vectors into HDR + byte packets for the host TX.
// Changes seen mid-packet coalesce into a single follow-up packet.
module irq_event_packer
  import flexdbg_pkg::*;
#(
  parameter int unsigned NIRQ = 32,
  parameter logic [7:0]  HDR  = IRQ_HDR
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            ENABLE,
  input  logic            IRQ_VALID,
  input  logic [NIRQ-1:0] IRQ_VEC,
  output logic            WREN,
  output logic [7:0]      WRDATA,
  input  logic            WRFULL,
  output logic            BUSY,
  output logic [7:0]      DROPPED
);

  localparam int unsigned NBYTES = NIRQ / 8;
  localparam logic [2:0]  LAST   = 3'(NBYTES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cnt;
  logic [NIRQ-1:0]   last_sent;
  logic [NIRQ-1:0]   pend_vec;
  logic [NIRQ-1:0]   shadow;
  logic [NIRQ-1:0]   ref_vec;
  logic              pend;
  logic              launch;
  logic              take;
  logic              drop_hit;

  // Launch of a new packet snapshots pend_vec; compare against that.
  assign take     = IRQ_VALID && ENABLE;
  assign ref_vec  = launch ? pend_vec : last_sent;
  assign drop_hit = take && pend && !launch
                 && (IRQ_VEC != pend_vec)
                 && (DROPPED != 8'hFF);
  assign BUSY     = (state != IDLE) || pend;

  // Next state, write strobe and outgoing byte.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    WREN      = 1'b0;
    WRDATA    = 8'h00;
    unique case (state)
      IDLE: begin
        if (pend && ENABLE) begin
          launch    = 1'b1;
          state_nxt = SEND_HDR;
        end
      end
      SEND_HDR: begin
        WREN   = !WRFULL;
        WRDATA = HDR;
        if (!WRFULL) state_nxt = SEND_DATA;
      end
      SEND_DATA: begin
        WREN   = !WRFULL;
        WRDATA = shadow[{cnt, 3'b000} +: 8];
        if (!WRFULL && cnt == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Byte index: zeroed by the header write, stepped per data write.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt <= 3'd0;
    end else if (WREN) begin
      if (state == SEND_HDR || cnt == LAST) cnt <= 3'd0;
      else                                  cnt <= cnt + 3'd1;
    end
  end

  // Packet snapshot and last reported vector.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      shadow    <= '0;
      last_sent <= '0;
    end else if (launch) begin
      shadow    <= pend_vec;
      last_sent <= pend_vec;
    end else if (state == IDLE && !ENABLE) begin
      last_sent <= '0;
    end
  end

  // Pending vector and flag; a new scan overrides a launch clear.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      pend_vec <= '0;
      pend     <= 1'b0;
    end else if (!ENABLE) begin
      pend <= 1'b0;
    end else if (take) begin
      pend_vec <= IRQ_VEC;
      pend     <= (IRQ_VEC != ref_vec);
    end else if (launch) begin
      pend <= 1'b0;
    end
  end

  // Saturating count of superseded, never-sent vectors.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)       DROPPED <= 8'h00;
    else if (drop_hit) DROPPED <= DROPPED + 8'h01;
  end

endmodule

// File: tb/tb_irq_event_packer.sv
// Directed bench for irq_event_packer with NIRQ=32.
// Captures every written byte and compares against hand-built packets.
module tb_irq_event_packer;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        ENABLE = 1'b1;
  logic        IRQ_VALID = 1'b0;
  logic [31:0] IRQ_VEC = '0;
  logic        WREN;
  logic [7:0]  WRDATA;
  logic        WRFULL = 1'b0;
  logic        BUSY;
  logic [7:0]  DROPPED;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          t_valid = 0;
  logic [7:0]  q[$];
  int          qc[$];

  irq_event_packer dut (
    .CLK(CLK),
    .RESETn(RESETn),
    .ENABLE(ENABLE),
    .IRQ_VALID(IRQ_VALID),
    .IRQ_VEC(IRQ_VEC),
    .WREN(WREN),
    .WRDATA(WRDATA),
    .WRFULL(WRFULL),
    .BUSY(BUSY),
    .DROPPED(DROPPED)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (WREN) begin
      q.push_back(WRDATA);
      qc.push_back(cyc);
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [31:0] v);
    t_valid   = cyc;
    IRQ_VEC   = v;
    IRQ_VALID = 1'b1;
    tick();
    IRQ_VALID = 1'b0;
  endtask

  task automatic expect_pkt(input string tag,
                            input logic [31:0] vec,
                            input int t0);
    logic [7:0] b;
    int         n;
    check({tag, "_len"}, 64'(q.size() >= 5), 64'd1);
    n = (q.size() < 5) ? q.size() : 5;
    if (t0 >= 0 && n == 5) begin
      check({tag, "_t_hdr"}, 64'(qc[0]), 64'(t0 + 2));
      check({tag, "_t_end"}, 64'(qc[4]), 64'(t0 + 6));
    end
    for (int k = 0; k < n; k++) begin
      b = (k == 0) ? 8'hF1 : vec[(k-1)*8 +: 8];
      check($sformatf("%s_b%0d", tag, k), 64'(q[0]), 64'(b));
      void'(q.pop_front());
      void'(qc.pop_front());
    end
  endtask

  initial begin
    logic busy_seen;

    #2;
    check("rst_wren", 64'(WREN), 64'd0);
    check("rst_wrdata", 64'(WRDATA), 64'h00);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_dropped", 64'(DROPPED), 64'h00);
    run(2);
    RESETn = 1'b1;
    run(2);

    pulse(32'h0000_0001);
    run(8);
    expect_pkt("basic", 32'h0000_0001, t_valid);
    check("basic_tail", 64'(q.size()), 64'd0);

    pulse(32'h0000_0001);
    busy_seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      busy_seen = busy_seen | BUSY;
    end
    #1;
    check("same_busy", 64'(busy_seen), 64'd0);
    check("same_nopkt", 64'(q.size()), 64'd0);

    pulse(32'h0000_0003);
    run(3);
    WRFULL = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("full_wren", 64'(WREN), 64'd0);
      check("full_data", 64'(WRDATA), 64'h00);
      check("full_busy", 64'(BUSY), 64'd1);
      tick();
    end
    WRFULL = 1'b0;
    run(8);
    expect_pkt("full", 32'h0000_0003, -1);
    check("full_once", 64'(q.size()), 64'd0);

    pulse(32'h0000_0040);
    run(2);
    pulse(32'h0000_0010);
    pulse(32'h0000_0020);
    run(16);
    check("coal_cnt", 64'(q.size()), 64'd10);
    expect_pkt("coal_a", 32'h0000_0040, -1);
    expect_pkt("coal_b", 32'h0000_0020, -1);
    check("coal_drop", 64'(DROPPED), 64'h01);

    pulse(32'h0000_0055);
    run(3);
    RESETn = 1'b0;
    #1;
    check("arst_wren", 64'(WREN), 64'd0);
    check("arst_data", 64'(WRDATA), 64'h00);
    check("arst_busy", 64'(BUSY), 64'd0);
    check("arst_drop", 64'(DROPPED), 64'h00);
    run(2);
    RESETn = 1'b1;
    q.delete();
    qc.delete();
    run(6);
    check("arst_noresume", 64'(q.size()), 64'd0);
    pulse(32'h0000_0000);
    run(8);
    check("arst_zero", 64'(q.size()), 64'd0);
    check("arst_zbusy", 64'(BUSY), 64'd0);
    pulse(32'h8000_0000);
    run(8);
    expect_pkt("arst_msb", 32'h8000_0000, t_valid);

    pulse(32'h0000_00AA);
    tick();
    ENABLE = 1'b0;
    run(8);
    pulse(32'h0000_0077);
    run(6);
    expect_pkt("dis", 32'h0000_00AA, -1);
    check("dis_ignore", 64'(q.size()), 64'd0);
    check("dis_busy", 64'(BUSY), 64'd0);
    ENABLE = 1'b1;
    tick();
    pulse(32'h0000_0000);
    run(8);
    check("reen_zero", 64'(q.size()), 64'd0);
    check("reen_busy", 64'(BUSY), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
